// File: rtl/scan_decoder_pkg.sv
// Shared encodings for the scan decoder: request modes and controller states.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/scan_decoder_index_decoder.sv
// Combinational index decoder: one-hot of the index, or bits index..0 when
// thermometer select is high.
module index_decoder #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      i_idx,
    input  logic                 i_therm,
    output logic [2**IN_W-1:0]   o_vec
);
    localparam int OUT_W = 2**IN_W;

    always_comb begin
        o_vec = '0;
        for (int b = 0; b < OUT_W; b++) begin
            o_vec[b] = i_therm ? (b <= int'(i_idx)) : (b == int'(i_idx));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered index decoder with a one-shot scan mode that walks the one-hot
// output from a start index up to the top bit, holding each for DWELL cycles.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int DWELL = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [IN_W-1:0]      i_in,
    input  logic                 i_good,
    input  logic [1:0]           i_mode,
    output logic [2**IN_W-1:0]   o_out,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int OUT_W = 2**IN_W;
    localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DW_LAST  = DW'(DWELL - 1);
    localparam logic [IN_W-1:0] IDX_LAST = IN_W'(OUT_W - 1);

    state_e             r_state, w_state_nxt;
    logic [OUT_W-1:0]   r_out, w_out_nxt, w_dec;
    logic [DW-1:0]      r_dwell, w_dwell_nxt;
    logic [IN_W-1:0]    r_idx, w_idx_nxt, w_dec_idx;
    logic               r_busy, r_done, w_busy_nxt, w_done_nxt, w_therm;

    // One shared decoder: request index while idle, next scan index while scanning.
    assign w_dec_idx = (r_state == IDLE) ? i_in : r_idx + IN_W'(1);
    assign w_therm   = (r_state == IDLE) && (mode_e'(i_mode) == MODE_THERM);

    index_decoder #(.IN_W(IN_W)) u_dec (
        .i_idx   (w_dec_idx),
        .i_therm (w_therm),
        .o_vec   (w_dec)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = '0;
        w_dwell_nxt = r_dwell;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                w_dwell_nxt = '0;
                w_idx_nxt   = '0;
                if (i_good) begin
                    case (mode_e'(i_mode))
                        MODE_ONEHOT, MODE_THERM: w_out_nxt = w_dec;
                        MODE_SCAN: begin
                            w_state_nxt = SCAN;
                            w_idx_nxt   = i_in;
                            w_out_nxt   = w_dec;
                        end
                        default: w_out_nxt = '0;
                    endcase
                end
            end
            SCAN: begin
                if (r_done) begin
                    w_state_nxt = IDLE;
                    w_dwell_nxt = '0;
                    w_idx_nxt   = '0;
                end else if (r_dwell == DW_LAST) begin
                    w_dwell_nxt = '0;
                    w_idx_nxt   = r_idx + IN_W'(1);
                    w_out_nxt   = w_dec;
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                    w_out_nxt   = r_out;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Done is registered, so it is predicted from the next-cycle scan position.
        w_busy_nxt = (w_state_nxt == SCAN);
        w_done_nxt = w_busy_nxt && (w_idx_nxt == IDX_LAST) && (w_dwell_nxt == DW_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_dwell <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_dwell <= w_dwell_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_out  = r_out;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
